// File: rtl/pe_bridge_pkg.sv
// Shared register map and bit positions for the PE host bridge.
// No logic; constants only.
// Used by the bridge top and the testbench alike.
package pe_bridge_pkg;

    // Host word addresses
    localparam int ADDR_CTRL      = 'h00;
    localparam int ADDR_STATUS    = 'h01;
    localparam int ADDR_STAT_CLR  = 'h02;
    localparam int ADDR_IMEM_ADDR = 'h03;
    localparam int ADDR_COMMIT    = 'h04;
    localparam int ADDR_IMEM_DATA = 'h08;   // lane k at ADDR_IMEM_DATA + k
    localparam int ADDR_RESULT    = 'h10;   // lane k at ADDR_RESULT + k
    localparam int ADDR_POP       = 'h18;

    // CTRL bits
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    // STATUS bits
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_IRQ       = 3;
    localparam int ST_COUNT_LSB = 8;

    // STAT_CLR bit that clears the sticky overflow flag
    localparam int STCLR_OVERFLOW = 2;

endpackage

// File: rtl/pe_result_fifo.sv
// Result FIFO: holds completed PE result vectors, head visible combinationally.
// Latency: push visible at head/count the cycle after the push edge.
// Backpressure: full push without pop is dropped and flagged on overflow; pop on empty is ignored.
module pe_result_fifo #(
    parameter int Width = 128,
    parameter int Depth = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [Width-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [Width-1:0]             head,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(Depth));
    assign count    = cnt;
    assign head     = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign overflow = push & full & ~pop_ok & ~clear;

    // Pointer and occupancy tracking; clear overrides everything including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents only become visible through the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_host_bridge.sv
// Host-bus bridge to one PE: IMEM staging/commit, shader reset, result FIFO readout, IRQ.
// Latency: reads return 1 cycle after the strobe; commit pulses 1 cycle after the COMMIT write.
// Backpressure: none on the host bus; results arriving while the FIFO is full are dropped (sticky overflow).
module pe_host_bridge
    import pe_bridge_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int NumLanes      = 4,
    parameter int ImemAddrWidth = 10,
    parameter int ResultDepth   = 16,
    parameter int BusAddrWidth  = 6
) (
    input  logic                          iClk,
    input  logic                          iReset_n,
    input  logic                          iChipSelect_n,
    input  logic                          iWrite_n,
    input  logic                          iRead_n,
    input  logic [BusAddrWidth-1:0]       iAddress,
    input  logic [DataWidth-1:0]          iData,
    output logic [DataWidth-1:0]          oData,
    output logic                          oReadValid,
    output logic                          oImemWrEn,
    output logic [ImemAddrWidth-1:0]      oImemWrAddr,
    output logic [DataWidth*NumLanes-1:0] oImemWrData,
    output logic                          oShaderRst_n,
    input  logic [DataWidth*NumLanes-1:0] iPeData,
    input  logic [NumLanes-1:0]           iPeReady,
    output logic                          oIrq
);
    localparam int CW = $clog2(ResultDepth + 1);

    // Bus strobes; a write takes precedence and suppresses a simultaneous read
    logic wr_en;
    logic rd_en;
    assign wr_en = ~iChipSelect_n & ~iWrite_n;
    assign rd_en = ~iChipSelect_n & ~iRead_n & iWrite_n;

    logic hit_ctrl, hit_status, hit_stat_clr, hit_imem_addr, hit_commit, hit_pop;
    assign hit_ctrl      = (iAddress == BusAddrWidth'(ADDR_CTRL));
    assign hit_status    = (iAddress == BusAddrWidth'(ADDR_STATUS));
    assign hit_stat_clr  = (iAddress == BusAddrWidth'(ADDR_STAT_CLR));
    assign hit_imem_addr = (iAddress == BusAddrWidth'(ADDR_IMEM_ADDR));
    assign hit_commit    = (iAddress == BusAddrWidth'(ADDR_COMMIT));
    assign hit_pop       = (iAddress == BusAddrWidth'(ADDR_POP));

    logic                                run;
    logic                                irq_en;
    logic                                overflow;
    logic [ImemAddrWidth-1:0]            imem_addr;
    logic [NumLanes-1:0][DataWidth-1:0]  imem_data;
    logic                                all_rdy;
    logic                                all_rdy_q;
    logic [DataWidth-1:0]                rd_mux;

    logic                                fifo_push;
    logic                                fifo_pop;
    logic                                fifo_clear;
    logic [DataWidth*NumLanes-1:0]       fifo_head;
    logic [CW-1:0]                       fifo_count;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                fifo_ovf;

    logic                                commit_wr;
    assign commit_wr = wr_en & hit_commit;

    assign oShaderRst_n = run;

    // One entry per result: only the rising edge of the combined ready pushes
    assign all_rdy    = (&iPeReady) & run;
    assign fifo_push  = all_rdy & ~all_rdy_q;
    assign fifo_pop   = wr_en & hit_pop;
    assign fifo_clear = wr_en & hit_ctrl & iData[CTRL_CLEAR];

    pe_result_fifo #(
        .Width (DataWidth * NumLanes),
        .Depth (ResultDepth)
    ) u_fifo (
        .clk       (iClk),
        .rst_n     (iReset_n),
        .push      (fifo_push),
        .push_data (iPeData),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // CTRL register, sticky overflow flag and ready edge history
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            run       <= 1'b0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            all_rdy_q <= 1'b0;
        end else begin
            all_rdy_q <= all_rdy;
            if (wr_en && hit_ctrl) begin
                run    <= iData[CTRL_RUN];
                irq_en <= iData[CTRL_IRQ_EN];
            end
            // A fresh drop in the same cycle as the clear keeps the flag set
            if (fifo_ovf)
                overflow <= 1'b1;
            else if (wr_en && hit_stat_clr && iData[STCLR_OVERFLOW])
                overflow <= 1'b0;
        end
    end

    // IMEM staging: address (with commit auto-increment) and per-lane data words
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            imem_addr <= '0;
            imem_data <= '0;
        end else begin
            if (commit_wr && iData[0])
                imem_addr <= imem_addr + ImemAddrWidth'(1);
            else if (wr_en && hit_imem_addr)
                imem_addr <= iData[ImemAddrWidth-1:0];
            for (int k = 0; k < NumLanes; k++) begin
                if (wr_en && iAddress == BusAddrWidth'(ADDR_IMEM_DATA + k))
                    imem_data[k] <= iData;
            end
        end
    end

    // Commit pulse: address/data are snapshotted at the COMMIT edge so later staging writes cannot disturb it
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oImemWrEn   <= 1'b0;
            oImemWrAddr <= '0;
            oImemWrData <= '0;
        end else begin
            oImemWrEn <= commit_wr;
            if (commit_wr) begin
                oImemWrAddr <= imem_addr;
                oImemWrData <= imem_data;
            end
        end
    end

    // Read data selection; unmapped and write-only addresses read as zero
    always_comb begin
        rd_mux = '0;
        if (hit_ctrl) begin
            rd_mux[CTRL_RUN]    = run;
            rd_mux[CTRL_IRQ_EN] = irq_en;
        end
        if (hit_status) begin
            rd_mux[ST_EMPTY]             = fifo_empty;
            rd_mux[ST_FULL]              = fifo_full;
            rd_mux[ST_OVERFLOW]          = overflow;
            rd_mux[ST_IRQ]               = oIrq;
            rd_mux[ST_COUNT_LSB +: CW]   = fifo_count;
        end
        if (hit_imem_addr)
            rd_mux[ImemAddrWidth-1:0] = imem_addr;
        for (int k = 0; k < NumLanes; k++) begin
            if (iAddress == BusAddrWidth'(ADDR_IMEM_DATA + k))
                rd_mux = imem_data[k];
            if (iAddress == BusAddrWidth'(ADDR_RESULT + k) && !fifo_empty)
                rd_mux = fifo_head[k*DataWidth +: DataWidth];
        end
    end

    // Registered read port; oData holds until the next read
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData      <= '0;
            oReadValid <= 1'b0;
        end else begin
            oReadValid <= rd_en;
            if (rd_en) oData <= rd_mux;
        end
    end

    // Level interrupt, registered from the current FIFO/overflow state
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) oIrq <= 1'b0;
        else           oIrq <= irq_en & (~fifo_empty | overflow);
    end

endmodule

// File: tb/tb_pe_host_bridge.sv
module tb_pe_host_bridge;
    import pe_bridge_pkg::*;

    localparam int DW  = 32;
    localparam int NL  = 4;
    localparam int IAW = 10;
    localparam int RD  = 16;
    localparam int BAW = 6;

    logic              iClk;
    logic              iReset_n;
    logic              iChipSelect_n;
    logic              iWrite_n;
    logic              iRead_n;
    logic [BAW-1:0]    iAddress;
    logic [DW-1:0]     iData;
    logic [DW-1:0]     oData;
    logic              oReadValid;
    logic              oImemWrEn;
    logic [IAW-1:0]    oImemWrAddr;
    logic [DW*NL-1:0]  oImemWrData;
    logic              oShaderRst_n;
    logic [DW*NL-1:0]  iPeData;
    logic [NL-1:0]     iPeReady;
    logic              oIrq;

    pe_host_bridge #(
        .DataWidth     (DW),
        .NumLanes      (NL),
        .ImemAddrWidth (IAW),
        .ResultDepth   (RD),
        .BusAddrWidth  (BAW)
    ) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iChipSelect_n (iChipSelect_n),
        .iWrite_n      (iWrite_n),
        .iRead_n       (iRead_n),
        .iAddress      (iAddress),
        .iData         (iData),
        .oData         (oData),
        .oReadValid    (oReadValid),
        .oImemWrEn     (oImemWrEn),
        .oImemWrAddr   (oImemWrAddr),
        .oImemWrData   (oImemWrData),
        .oShaderRst_n  (oShaderRst_n),
        .iPeData       (iPeData),
        .iPeReady      (iPeReady),
        .oIrq          (oIrq)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    string         name_q[$];

    int              imem_pulses = 0;
    logic [IAW-1:0]  last_addr = '0;
    logic [DW*NL-1:0] last_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for read returns, plus IMEM write pulse capture
    always @(negedge iClk) begin
        if (iReset_n && oReadValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h with nothing expected", oData);
            end else begin
                logic [DW-1:0] e;
                string         n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, 128'(oData), 128'(e));
            end
        end
        if (oImemWrEn) begin
            imem_pulses++;
            last_addr = oImemWrAddr;
            last_data = oImemWrData;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [DW*NL-1:0] pat(input int i);
        logic [DW*NL-1:0] r;
        for (int l = 0; l < NL; l++)
            r[l*DW +: DW] = 32'hC000_0000 | 32'(i << 8) | 32'(l);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic bus_wr(input int a, input logic [DW-1:0] d);
        iChipSelect_n = 1'b0;
        iWrite_n      = 1'b0;
        iAddress      = BAW'(a);
        iData         = d;
        @(posedge iClk);
        #1;
        iChipSelect_n = 1'b1;
        iWrite_n      = 1'b1;
    endtask

    task automatic bus_rd(input int a, input logic [DW-1:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        iChipSelect_n = 1'b0;
        iRead_n       = 1'b0;
        iAddress      = BAW'(a);
        @(posedge iClk);
        #1;
        iChipSelect_n = 1'b1;
        iRead_n       = 1'b1;
    endtask

    task automatic pe_pulse(input int i);
        iPeData  = pat(i);
        iPeReady = '1;
        @(posedge iClk);
        #1;
        iPeReady = '0;
        @(posedge iClk);
        #1;
    endtask

    task automatic push_pop(input int i);
        iPeData       = pat(i);
        iPeReady      = '1;
        iChipSelect_n = 1'b0;
        iWrite_n      = 1'b0;
        iAddress      = BAW'(ADDR_POP);
        @(posedge iClk);
        #1;
        iPeReady      = '0;
        iChipSelect_n = 1'b1;
        iWrite_n      = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    logic [DW*NL-1:0] v;

    initial begin
        iReset_n      = 1'b0;
        iChipSelect_n = 1'b1;
        iWrite_n      = 1'b1;
        iRead_n       = 1'b1;
        iAddress      = '0;
        iData         = '0;
        iPeData       = '0;
        iPeReady      = '0;
        idle(3);

        // Reset state
        check("rst_shader_rst_n", 128'(oShaderRst_n), 128'(0));
        check("rst_irq",          128'(oIrq),         128'(0));
        check("rst_imem_wr_en",   128'(oImemWrEn),    128'(0));
        check("rst_read_valid",   128'(oReadValid),   128'(0));
        check("rst_data",         128'(oData),        128'(0));
        iReset_n = 1'b1;
        idle(1);
        bus_rd(ADDR_STATUS, 32'h0000_0001, "status_after_reset");

        // IMEM staging and commit with wrap of the auto-increment
        bus_wr(ADDR_IMEM_ADDR, 32'h0000_03FF);
        bus_rd(ADDR_IMEM_ADDR, 32'h0000_03FF, "imem_addr_rb");
        bus_wr(ADDR_IMEM_DATA + 0, 32'hAAAA_0000);
        bus_wr(ADDR_IMEM_DATA + 1, 32'hBBBB_0001);
        bus_wr(ADDR_IMEM_DATA + 2, 32'hCCCC_0002);
        bus_wr(ADDR_IMEM_DATA + 3, 32'hDDDD_0003);
        bus_rd(ADDR_IMEM_DATA + 2, 32'hCCCC_0002, "imem_lane2_rb");
        bus_wr(ADDR_COMMIT, 32'h0000_0001);
        idle(2);
        check("commit_pulses", 128'(imem_pulses), 128'(1));
        check("commit_addr",   128'(last_addr),   128'(10'h3FF));
        check("commit_data",   128'(last_data),   128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000);
        bus_rd(ADDR_IMEM_ADDR, 32'h0, "imem_addr_wrapped");

        // Unmapped accesses
        bus_wr('h06, 32'hFFFF_FFFF);
        bus_rd('h05, 32'h0, "unmapped_read");
        bus_rd('h0F, 32'h0, "lane_beyond_numlanes");
        bus_rd(ADDR_CTRL, 32'h0, "ctrl_after_unmapped_wr");

        // Run with IRQ enabled, single result round trip
        bus_wr(ADDR_CTRL, 32'h3);
        check("shader_running", 128'(oShaderRst_n), 128'(1));
        bus_rd(ADDR_CTRL, 32'h3, "ctrl_rb");
        v = pat(100);
        pe_pulse(100);
        bus_rd(ADDR_STATUS, 32'h0000_0108, "status_one_entry");
        bus_rd(ADDR_RESULT + 2, v[95:64], "result_lane2");
        check("irq_pending", 128'(oIrq), 128'(1));
        bus_wr(ADDR_POP, 32'h0);
        idle(1);
        check("irq_after_pop", 128'(oIrq), 128'(0));
        bus_rd(ADDR_STATUS, 32'h0000_0001, "status_after_pop");
        bus_rd(ADDR_RESULT + 0, 32'h0, "result_when_empty");

        // Held ready produces exactly one entry
        iPeData  = pat(7);
        iPeReady = '1;
        idle(5);
        iPeReady = '0;
        idle(2);
        bus_rd(ADDR_STATUS, 32'h0000_0108, "held_ready_one_entry");
        bus_wr(ADDR_POP, 32'h0);
        idle(1);

        // Overfill: 17 results into a 16-deep FIFO
        for (int i = 0; i < 17; i++) pe_pulse(i);
        bus_rd(ADDR_STATUS, 32'h0000_100E, "status_full_overflow");
        v = pat(0);
        bus_rd(ADDR_RESULT + 0, v[31:0], "head_oldest");
        bus_wr(ADDR_STAT_CLR, 32'h4);
        bus_rd(ADDR_STATUS, 32'h0000_100A, "status_ovf_cleared");

        // Full with simultaneous push and pop
        push_pop(17);
        bus_rd(ADDR_STATUS, 32'h0000_100A, "full_push_pop_count");
        v = pat(1);
        bus_rd(ADDR_RESULT + 0, v[31:0],   "head_advanced_l0");
        bus_rd(ADDR_RESULT + 3, v[127:96], "head_advanced_l3");

        // FIFO clear via CTRL bit2
        bus_wr(ADDR_CTRL, 32'h7);
        idle(1);
        bus_rd(ADDR_STATUS, 32'h0000_0001, "status_after_clear");
        bus_rd(ADDR_CTRL, 32'h3, "ctrl_clear_reads_0");

        // Empty with simultaneous push and pop
        push_pop(50);
        bus_rd(ADDR_STATUS, 32'h0000_0108, "empty_push_pop_count");
        v = pat(50);
        bus_rd(ADDR_RESULT + 0, v[31:0], "empty_push_pop_head");

        // IRQ masked while data is pending
        bus_wr(ADDR_CTRL, 32'h1);
        idle(1);
        check("irq_masked", 128'(oIrq), 128'(0));

        // Reset asserted while a COMMIT write is on the bus
        iChipSelect_n = 1'b0;
        iWrite_n      = 1'b0;
        iAddress      = BAW'(ADDR_COMMIT);
        iData         = 32'h1;
        #2;
        iReset_n = 1'b0;
        @(posedge iClk);
        #1;
        iChipSelect_n = 1'b1;
        iWrite_n      = 1'b1;
        idle(2);
        check("reset_commit_no_wr_en", 128'(oImemWrEn),  128'(0));
        check("reset_commit_pulses",   128'(imem_pulses), 128'(1));
        check("reset_shader_rst_n",    128'(oShaderRst_n), 128'(0));
        iReset_n = 1'b1;
        idle(1);
        bus_rd(ADDR_STATUS, 32'h0000_0001, "status_after_reset2");
        bus_rd(ADDR_IMEM_ADDR, 32'h0, "imem_addr_after_reset2");
        idle(3);
        check("pulses_final", 128'(imem_pulses), 128'(1));
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
